// File: rtl/sm83_bus_ctrl.sv
// SM83 external bus controller: region decode, per-region strobes with wait states, 0xFF50 boot latch.
// Define SM83_BUS_ECHO_RAM_EN to mirror WRAM into 0xE000-0xFDFF.
module sm83_bus_ctrl #(
  parameter int BOOT_WAIT = 0,
  parameter int CART_WAIT = 1,
  parameter int WRAM_WAIT = 0,
  parameter int WRAM_AW   = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_wdata,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_ready,
  output logic               boot_cs,
  output logic               boot_oe,
  output logic [7:0]         boot_addr,
  input  logic [7:0]         boot_dout,
  output logic               cart_cs,
  output logic               cart_oe,
  output logic [14:0]        cart_addr,
  input  logic [7:0]         cart_dout,
  output logic               wram_cs,
  output logic               wram_oe,
  output logic               wram_wr,
  output logic [WRAM_AW-1:0] wram_addr,
  output logic [7:0]         wram_din,
  input  logic [7:0]         wram_dout,
  output logic               boot_active
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic [2:0] {RG_NONE, RG_BOOT, RG_CART, RG_WRAM, RG_LATCH} region_e;

  state_e      state_q, state_d;
  region_e     region_q, region_d, regionDec;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  readMux;
  logic        write_q, write_d;
  logic        boot_q, boot_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  waitDec;
  logic        inAccess;

  always_comb begin
    regionDec = RG_NONE;
    if (boot_q && cpu_addr[15:8] == 8'h00) regionDec = RG_BOOT;
    else if (!cpu_addr[15]) regionDec = RG_CART;
    else if (cpu_addr[15:13] == 3'b110) regionDec = RG_WRAM;
`ifdef SM83_BUS_ECHO_RAM_EN
    else if (cpu_addr[15:13] == 3'b111 && cpu_addr[12:9] != 4'hF) regionDec = RG_WRAM;
`endif
    else if (cpu_addr == 16'hFF50) regionDec = RG_LATCH;
    // ROM writes are discarded: treated as an unmapped, zero-wait access
    if (cpu_wr && (regionDec == RG_BOOT || regionDec == RG_CART)) regionDec = RG_NONE;
  end

  always_comb begin
    case (regionDec)
      RG_BOOT: waitDec = 4'(BOOT_WAIT);
      RG_CART: waitDec = 4'(CART_WAIT);
      RG_WRAM: waitDec = 4'(WRAM_WAIT);
      default: waitDec = 4'd0;
    endcase
  end

  always_comb begin
    case (region_q)
      RG_BOOT:  readMux = boot_dout;
      RG_CART:  readMux = cart_dout;
      RG_WRAM:  readMux = wram_dout;
      RG_LATCH: readMux = {7'h7F, ~boot_q};
      default:  readMux = 8'hFF;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    boot_d   = boot_q;
    case (state_q)
      IDLE: begin
        if (cpu_rd || cpu_wr) begin
          addr_d   = cpu_addr[14:0];
          wdata_d  = cpu_wdata;
          write_d  = cpu_wr;
          region_d = regionDec;
          cnt_d    = waitDec;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!write_q) rdata_d = readMux;
          else if (region_q == RG_LATCH && wdata_q != 8'h00) boot_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      region_q <= RG_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      boot_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      boot_q   <= boot_d;
    end
  end

  // Strobes come straight from registered state so they are clean for the whole access
  assign inAccess    = (state_q == ACCESS);
  assign boot_cs     = inAccess && region_q == RG_BOOT;
  assign boot_oe     = boot_cs && !write_q;
  assign cart_cs     = inAccess && region_q == RG_CART;
  assign cart_oe     = cart_cs && !write_q;
  assign wram_cs     = inAccess && region_q == RG_WRAM;
  assign wram_oe     = wram_cs && !write_q;
  assign wram_wr     = wram_cs && write_q;
  assign boot_addr   = addr_q[7:0];
  assign cart_addr   = addr_q;
  assign wram_addr   = addr_q[WRAM_AW-1:0];
  assign wram_din    = wdata_q;
  assign cpu_ready   = (state_q == DONE);
  assign cpu_rdata   = rdata_q;
  assign boot_active = boot_q;

endmodule

// File: doc/sm83_bus_ctrl.md
# sm83_bus_ctrl

Parametrised external bus controller between `cpu_top` and the system memories. It replaces direct wiring of the CPU address and data buses to the boot ROM. It decodes every CPU access into boot ROM, cartridge ROM, WRAM or internal-register regions, and generates per-region chip-select, output-enable and write strobes with configurable wait states. It returns read data to the CPU through a ready handshake and owns the boot-ROM overlay disable latch at 0xFF50.

## Interface
Parameters:
- `BOOT_WAIT`, default 0: wait states for boot ROM accesses (0–15).
- `CART_WAIT`, default 1: wait states for cartridge ROM accesses (0–15).
- `WRAM_WAIT`, default 0: wait states for WRAM accesses (0–15).
- `WRAM_AW`, default 13: WRAM address width (10–13). The 0xC000–0xDFFF window aliases modulo 2^WRAM_AW.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  16  access address.
- `cpu_wdata`  in  8  write data.
- `cpu_rd`  in  1  read request; level, held until `cpu_ready`.
- `cpu_wr`  in  1  write request; level, held until `cpu_ready`.
- `cpu_rdata`  out  8  registered read data, valid while `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle access-complete pulse.
- `boot_cs`, `boot_oe`  out  1  boot ROM strobes.
- `boot_addr`  out  8  boot ROM address.
- `boot_dout`  in  8  boot ROM data.
- `cart_cs`, `cart_oe`  out  1  cartridge ROM strobes.
- `cart_addr`  out  15  cartridge ROM address.
- `cart_dout`  in  8  cartridge ROM data.
- `wram_cs`, `wram_oe`, `wram_wr`  out  1  WRAM strobes.
- `wram_addr`  out  WRAM_AW  WRAM address.
- `wram_din`  out  8  WRAM write data.
- `wram_dout`  in  8  WRAM read data.
- `boot_active`  out  1  overlay state; 1 = boot ROM mapped.

## Operation
Decode is performed on the address latched at acceptance:
- 0x0000–0x00FF while `boot_active`: boot ROM.
- Otherwise 0x0000–0x7FFF: cartridge ROM.
- 0xC000–0xDFFF: WRAM.
- 0xFF50: the boot latch.
- Everything else is unmapped.

Writes to ROM regions are dropped. Drop means no strobes and the access completes with zero wait states.

FSM states: IDLE, ACCESS, DONE.
- **IDLE:** waits for `cpu_rd` or `cpu_wr`. On a request it latches address, write data, direction and region, loads the wait counter with the region's WAIT value (0 for unmapped, dropped and 0xFF50), and moves to ACCESS.
- **ACCESS:** the selected region's cs is asserted; oe is asserted for reads and wr for writes. The counter decrements each cycle. When the counter is 0, read data is captured into `cpu_rdata` and the FSM moves to DONE.
- **DONE:** `cpu_ready`=1 for exactly this cycle, all strobes are low, requests are ignored, then the FSM returns to IDLE.

Read and write rules:
- `cpu_rd` and `cpu_wr` asserted together: the access is a write.
- Unmapped reads return 0xFF.
- A read of 0xFF50 returns {7'h7F, ~boot_active}.
- A write of a nonzero value to 0xFF50 clears `boot_active`. It stays cleared until reset.
- A write of 0x00 to 0xFF50 has no effect.

Reset (asynchronous, any state) sets:
- FSM to IDLE.
- All cs/oe/wr and `cpu_ready` to 0.
- `cpu_rdata` to 0x00.
- `boot_active` to 1.
- Address and data outputs to 0.

## Timing
- A request sampled at edge 0 gives strobes high from edge 0 for WAIT+1 cycles.
- Data is captured at edge WAIT+1; `cpu_ready` is high in the cycle after that edge.
- Read/write latency is WAIT+2 cycles from request sample to `cpu_ready`, and WAIT+3 cycles until the next request can be accepted.
- Back-to-back: a request still held during DONE is ignored and is re-sampled in IDLE.
- A new access must wait until `cpu_ready` has been seen.
- Address, data and region are stable for the whole access, even if `cpu_addr` changes mid-access.
- `wram_wr` is asserted for all WAIT+1 cycles; WRAM commits on the final edge.

## Configuration
- `SM83_BUS_ECHO_RAM_EN` defined: 0xE000–0xFDFF mirrors WRAM with the same strobes, WRAM_WAIT and address aliasing as 0xC000.
- `SM83_BUS_ECHO_RAM_EN` undefined: 0xE000–0xFDFF is unmapped; reads return 0xFF and writes are dropped.

## Test plan
- Read 0x0005 after reset with BOOT_WAIT=0 and `boot_dout`=0x31 -> `boot_cs`/`boot_oe` high for 1 cycle, `cpu_ready` 2 cycles after the request, `cpu_rdata`=0x31.
- Write 0x01 to 0xFF50, then read 0x0005 with CART_WAIT=1 and `cart_dout`=0xC3 -> `boot_active`=0, `cart_cs` high 2 cycles, ready after 3 cycles, data 0xC3; a read of 0xFF50 returns 0xFF.
- Write 0xA5 to 0xC123 with WRAM_WAIT=2, then read it back -> `wram_wr` high 3 cycles with `wram_addr`=0x0123 and `wram_din`=0xA5; the readback returns 0xA5 after 4 cycles.
- Read 0xE123 -> returns WRAM data when the macro is defined; returns 0xFF with no strobes when it is undefined.
- Assert `rst` during ACCESS of a cart read with CART_WAIT=5 -> all strobes drop immediately, `cpu_ready` never pulses, `boot_active` returns to 1.
- Assert `cpu_rd` and `cpu_wr` together to 0xC000 -> a write occurs with `wram_oe`=0.
